mem_access_unit: RTL and testbench

Load/store initiator for the single-clock 32-bit word BRAM in the RV32I multicycle core. It accepts one RV32I load or store request at a time from the control sequencer and drives the BRAM port (word address, write data, active-low write enable, 1-cycle registered read data). Byte and halfword loads are lane-extracted with sign or zero extension. Byte and halfword stores use read-modify-write, because the BRAM has no byte enables. Misaligned or illegal accesses complete with an error and never touch memory.

---
 rtl/mem_access_unit_if.sv | 27 ++
 rtl/mem_access_unit.sv | 83 ++++++++
 tb/tb_mem_access_unit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request and BRAM port signals of the load/store unit
interface mem_access_unit_if #(
  parameter int WORDS      = 10,
  parameter int DATA_WIDTH = 32
);
  logic                  req_i;
  logic                  we_i;
  logic [2:0]            funct3_i;
  logic [31:0]           addr_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic                  ready_o;
  logic                  done_o;
  logic                  err_o;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic [WORDS-1:0]      mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_data_o;
  logic                  mem_wen_no;
  logic [DATA_WIDTH-1:0] mem_data_i;
  modport master (
    output req_i, we_i, funct3_i, addr_i, wdata_i, mem_data_i,
    input  ready_o, done_o, err_o, rdata_o, mem_addr_o, mem_data_o, mem_wen_no
  );
  modport slave (
    input  req_i, we_i, funct3_i, addr_i, wdata_i, mem_data_i,
    output ready_o, done_o, err_o, rdata_o, mem_addr_o, mem_data_o, mem_wen_no
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32I load/store initiator for a byte-enable-less word BRAM
module mem_access_unit #(
  parameter int WORDS      = 10,
  parameter int DATA_WIDTH = 32
) (
  input logic               clk_i,
  input logic               reset_i,
  mem_access_unit_if.slave  bus
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD    = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] WR    = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [2:0] FAULT = 3'd5;
  logic [2:0]            state;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [1:0]            lane_q;
  logic [15:0]           wd_q;
  logic                  ill;
  logic                  mis;
  logic                  is_sw;
  logic [4:0]            bsh;
  logic [4:0]            hsh;
  logic [7:0]            sel_b;
  logic [15:0]           sel_h;
  logic [DATA_WIDTH-1:0] ext;
  logic [DATA_WIDTH-1:0] merged;
  assign bus.ready_o    = state == IDLE;
  assign bus.done_o     = state == DONE || state == FAULT;
  assign bus.err_o      = state == FAULT;
  assign bus.mem_wen_no = ~(state == WR) | reset_i;
  // request legality at acceptance, lane extraction and read-modify-write merge
  always_comb begin
    ill    = bus.we_i ? (bus.funct3_i[2] | (&bus.funct3_i[1:0]))
                      : ((&bus.funct3_i[1:0]) | (bus.funct3_i == 3'b110));
    mis    = (bus.funct3_i[1:0] == 2'b01 && bus.addr_i[0]) ||
             (bus.funct3_i[1:0] == 2'b10 && bus.addr_i[1:0] != 2'b00);
    is_sw  = bus.we_i && bus.funct3_i == 3'b010;
    bsh    = {lane_q, 3'b000};
    hsh    = {lane_q[1], 4'b0000};
    sel_b  = bus.mem_data_i[bsh +: 8];
    sel_h  = bus.mem_data_i[hsh +: 16];
    ext    = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & sel_b[7]}}, sel_b} :
             f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & sel_h[15]}}, sel_h} : bus.mem_data_i;
    merged = f3_q[0] ? (bus.mem_data_i & ~(32'h0000_FFFF << hsh)) | ({16'h0, wd_q} << hsh)
                     : (bus.mem_data_i & ~(32'h0000_00FF << bsh)) | ({24'h0, wd_q[7:0]} << bsh);
  end
  // sequencer: accept, read, merge/extract, write, complete
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state          <= IDLE;
      we_q           <= 1'b0;
      f3_q           <= 3'b000;
      lane_q         <= 2'b00;
      wd_q           <= 16'h0;
      bus.rdata_o    <= '0;
      bus.mem_addr_o <= '0;
      bus.mem_data_o <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req_i) begin
          we_q           <= bus.we_i;
          f3_q           <= bus.funct3_i;
          lane_q         <= bus.addr_i[1:0];
          wd_q           <= bus.wdata_i[15:0];
          bus.mem_addr_o <= bus.addr_i[WORDS+1:2];
          if (!(ill || mis) && is_sw) bus.mem_data_o <= bus.wdata_i;
          state          <= (ill || mis) ? FAULT : is_sw ? WR : RD;
        end
        RD:   state <= DATA;
        DATA: begin
          if (we_q) bus.mem_data_o <= merged;
          else bus.rdata_o <= ext;
          state <= we_q ? WR : DONE;
        end
        WR:      state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed scoreboard bench with a registered-read BRAM model
module tb_mem_access_unit;
  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] rd;
  } exp_t;
  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        bd_we = 1'b0;
  logic [9:0]  bd_addr = '0;
  logic [31:0] bd_data = '0;
  logic [31:0] mem [1024];
  exp_t        q[$];
  exp_t        e;
  int          cyc = 0;
  int          acc = 0;
  int          t_acc = 0;
  int          wen_lows = 0;
  int          wen_rel = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_rd = '0;
  mem_access_unit_if #(.WORDS(10), .DATA_WIDTH(32)) bus ();
  mem_access_unit #(.WORDS(10), .DATA_WIDTH(32)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );
  always #5 clk_i = ~clk_i;
  // BRAM model: write on low enable, registered read; bd_* is a bench-side preload port
  always @(posedge clk_i) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (!bus.mem_wen_no) mem[bus.mem_addr_o] <= bus.mem_data_o;
    bus.mem_data_i <= mem[bus.mem_addr_o];
  end
  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (bus.req_i && bus.ready_o && !reset_i) acc <= acc + 1;
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask
  // monitor: counts write strobes and scores every completion against the queue
  always @(negedge clk_i) begin
    if (!bus.mem_wen_no) begin
      wen_lows++;
      wen_rel = cyc - t_acc;
    end
    if (bus.done_o) begin
      if (q.size() == 0) chk("spurious_done", {31'b0, bus.done_o}, 32'h0);
      else begin
        e = q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("err", {31'b0, bus.err_o}, {31'b0, e.err});
        chk("rdata", bus.rdata_o, e.rd);
      end
    end
  end
  task automatic poke(input logic [9:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk_i); #1 bd_we = 1'b0;
    @(negedge clk_i); #2;
  endtask
  task automatic wait_ready();
    int n = 0;
    while (!bus.ready_o && n < 20) begin @(negedge clk_i); #2; n++; end
  endtask
  task automatic drain(input string nm);
    int n = 0;
    while (q.size() != 0 && n < 20) begin @(negedge clk_i); #2; n++; end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s timeout got %0d pending expected 0", nm, q.size());
      q.delete();
    end
    @(negedge clk_i); #2;
  endtask
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic er, input int lat,
                       input logic ld, input logic [31:0] ldv, input int nw,
                       input int wc, input string nm);
    int w0;
    wait_ready();
    w0 = wen_lows;
    bus.req_i = 1'b1; bus.we_i = we; bus.funct3_i = f3; bus.addr_i = a; bus.wdata_i = wd;
    t_acc = cyc;
    if (ld && !er) model_rd = ldv;
    q.push_back('{t_acc + lat, er, model_rd});
    @(posedge clk_i); #1 bus.req_i = 1'b0;
    drain(nm);
    chk({nm, "_writes"}, wen_lows - w0, nw);
    if (nw > 0) chk({nm, "_wen_cycle"}, wen_rel, wc);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got no finish expected finish");
    $fatal(1);
  end
  initial begin
    int w0;
    int a0;
    int n;
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.funct3_i = 3'b000; bus.addr_i = '0; bus.wdata_i = '0;
    repeat (3) @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i); #2;
    chk("rst_ready", {31'b0, bus.ready_o}, 32'h1);
    chk("rst_done", {31'b0, bus.done_o}, 32'h0);
    chk("rst_err", {31'b0, bus.err_o}, 32'h0);
    chk("rst_rdata", bus.rdata_o, 32'h0);
    chk("rst_mem_addr", {22'b0, bus.mem_addr_o}, 32'h0);
    chk("rst_mem_data", bus.mem_data_o, 32'h0);
    chk("rst_wen", {31'b0, bus.mem_wen_no}, 32'h1);
    poke(10'd2, 32'h8BAD_F00D);
    poke(10'd5, 32'h80FF_7F01);
    issue(1'b0, 3'b010, 32'h8,  '0, 1'b0, 3, 1'b1, 32'h8BAD_F00D, 0, 0, "lw");
    issue(1'b0, 3'b000, 32'h16, '0, 1'b0, 3, 1'b1, 32'hFFFF_FFFF, 0, 0, "lb");
    issue(1'b0, 3'b100, 32'h16, '0, 1'b0, 3, 1'b1, 32'h0000_00FF, 0, 0, "lbu");
    issue(1'b0, 3'b001, 32'h16, '0, 1'b0, 3, 1'b1, 32'hFFFF_80FF, 0, 0, "lh");
    issue(1'b0, 3'b101, 32'h14, '0, 1'b0, 3, 1'b1, 32'h0000_7F01, 0, 0, "lhu");
    issue(1'b0, 3'b010, 32'h6,  '0, 1'b1, 1, 1'b1, '0, 0, 0, "err_lw");
    issue(1'b1, 3'b001, 32'h3,  32'hFFFF, 1'b1, 1, 1'b0, '0, 0, 0, "err_sh");
    issue(1'b0, 3'b011, 32'h0,  '0, 1'b1, 1, 1'b1, '0, 0, 0, "err_f3");
    wait_ready();
    w0 = wen_lows;
    bus.req_i = 1'b1; bus.we_i = 1'b1; bus.funct3_i = 3'b000; bus.addr_i = 32'h15; bus.wdata_i = 32'hAB;
    t_acc = cyc;
    @(posedge clk_i); #1 bus.req_i = 1'b0;
    n = 0;
    while (cyc - t_acc < 2 && n < 10) begin @(negedge clk_i); n++; end
    @(posedge clk_i); #1 reset_i = 1'b1;
    @(negedge clk_i); #1;
    chk("rst_wr_wen", {31'b0, bus.mem_wen_no}, 32'h1);
    @(posedge clk_i); #1 reset_i = 1'b0;
    @(negedge clk_i); #2;
    model_rd = '0;
    chk("rst_wr_ready", {31'b0, bus.ready_o}, 32'h1);
    chk("rst_wr_done", {31'b0, bus.done_o}, 32'h0);
    chk("rst_wr_writes", wen_lows - w0, 0);
    chk("rst_wr_mem5", mem[5], 32'h80FF_7F01);
    chk("rst_wr_rdata", bus.rdata_o, 32'h0);
    issue(1'b1, 3'b000, 32'h15, 32'h0000_00AB, 1'b0, 4, 1'b0, '0, 1, 3, "sb");
    chk("sb_mem5", mem[5], 32'h80FF_AB01);
    issue(1'b1, 3'b001, 32'h16, 32'h0000_CAFE, 1'b0, 4, 1'b0, '0, 1, 3, "sh");
    chk("sh_mem5", mem[5], 32'hCAFE_AB01);
    issue(1'b1, 3'b010, 32'h10, 32'h1234_5678, 1'b0, 2, 1'b0, '0, 1, 1, "sw");
    chk("sw_mem4", mem[4], 32'h1234_5678);
    wait_ready();
    a0 = acc;
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.funct3_i = 3'b010; bus.addr_i = 32'h8;
    t_acc = cyc;
    q.push_back('{t_acc + 3, 1'b0, 32'h8BAD_F00D});
    q.push_back('{t_acc + 7, 1'b0, 32'h1234_5678});
    model_rd = 32'h1234_5678;
    @(posedge clk_i); #1 bus.addr_i = 32'h10;
    n = 0;
    while (acc - a0 < 2 && n < 20) begin @(posedge clk_i); #1; n++; end
    bus.req_i = 1'b0;
    drain("back_to_back");
    repeat (3) @(negedge clk_i);
    chk("b2b_accepts", acc - a0, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
